// File: rtl/sm2_pkg.sv
// rtl/sm2_pkg.sv - shared types and constants for the SM2 arithmetic blocks
package sm2_pkg;

  localparam int W_DEFAULT = 256;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_VERIFY = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BADARG  = 2'b01,
    ST_VFAIL   = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

endpackage

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - W-cycle MSB-first interleaved modular multiplier
module mod_mul_serial
  import sm2_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic         done,
  output logic [W-1:0] res
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    p_ext, dbl, dbl_r, sum;
  logic [W-1:0]  step;

  // One Horner step: acc = 2*acc mod p, then add b when the current bit of a is set.
  // With acc < p every intermediate fits in W+1 bits and needs one conditional subtract.
  always_comb begin
    p_ext = {1'b0, p_q};
    dbl   = {acc_q, 1'b0};
    dbl_r = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    sum   = dbl_r + (a_q[W-1] ? {1'b0, b_q} : {(W+1){1'b0}});
    step  = W'((sum >= p_ext) ? (sum - p_ext) : sum);
  end

  // The final step is reported combinationally so the whole product takes exactly W cycles.
  assign done = (cnt_q == CW'(1));
  assign res  = step;

  // Load operands on start, otherwise consume one bit of a per cycle while bits remain.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    p_d   = p_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      p_d   = p;
      acc_d = '0;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      acc_d = step;
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Operand and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_inv_host.sv
// rtl/mod_inv_host.sv - request-side controller and result checker for the modular inverter
module mod_inv_host
  import sm2_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int TO_CYCLES = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_p,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_inv,
  output logic [1:0]   rsp_status,
  output logic         inv_start,
  output logic [W-1:0] inv_in,
  output logic [W-1:0] inv_p,
  input  logic [W-1:0] inv_res,
  input  logic         inv_finish,
  output logic         inv_kill
);

  localparam int WDW = $clog2(TO_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYCLES - 1);

  state_e         state_q, state_d;
  status_e        status_q, status_d;
  logic [W-1:0]   a_q, a_d, p_q, p_d, x_q, x_d, inv_q, inv_d;
  logic           x_bad_q, x_bad_d;
  logic           kill_q, kill_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           bad_arg;
  logic           mul_start, mul_done;
  logic [W-1:0]   mul_res;

  // The inverter only handles odd moduli of at least 3 with 0 < a < p.
  assign bad_arg = (a_q == '0) || (a_q >= p_q) || !p_q[0] || (p_q < W'(3));

  // Check a*x mod p == 1, with x taken straight from the inverter on its finish pulse.
  mod_mul_serial #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a_q),
    .b     (inv_res),
    .p     (p_q),
    .done  (mul_done),
    .res   (mul_res)
  );

  // Next-state and datapath control for the job sequence.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    a_d       = a_q;
    p_d       = p_q;
    x_d       = x_q;
    x_bad_d   = x_bad_q;
    inv_d     = inv_q;
    wd_d      = wd_q;
    kill_d    = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          p_d     = req_p;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_arg) begin
          status_d = ST_BADARG;
          inv_d    = '0;
          state_d  = S_RESP;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A finish pulse takes priority over the terminal watchdog count.
        if (inv_finish) begin
          x_d       = inv_res;
          x_bad_d   = (inv_res >= p_q);
          mul_start = 1'b1;
          state_d   = S_VERIFY;
        end else if (wd_q == WD_LAST) begin
          status_d = ST_TIMEOUT;
          inv_d    = '0;
          kill_d   = 1'b1;
          state_d  = S_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_VERIFY: begin
        // x >= p still runs the full multiply so VERIFY always lasts W cycles.
        if (mul_done) begin
          inv_d    = x_q;
          status_d = (!x_bad_q && (mul_res == W'(1))) ? ST_OK : ST_VFAIL;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          status_d = ST_OK;
          inv_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers; reset returns to IDLE on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      a_q      <= '0;
      p_q      <= '0;
      x_q      <= '0;
      x_bad_q  <= 1'b0;
      inv_q    <= '0;
      wd_q     <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      a_q      <= a_d;
      p_q      <= p_d;
      x_q      <= x_d;
      x_bad_q  <= x_bad_d;
      inv_q    <= inv_d;
      wd_q     <= wd_d;
      kill_q   <= kill_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_inv    = inv_q;
  assign rsp_status = status_q;
  assign inv_start  = (state_q == S_LAUNCH);
  assign inv_in     = a_q;
  assign inv_p      = p_q;
  assign inv_kill   = rst | kill_q;

endmodule

// File: tb/tb_mod_inv_host.sv
// tb/tb_mod_inv_host.sv - directed bench for mod_inv_host with a behavioural inverter stub
module tb_mod_inv_host;
  import sm2_pkg::*;

  localparam int W  = 256;
  localparam int TO = 2048;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] req_a, req_p, rsp_inv, inv_in, inv_p, inv_res;
  logic [1:0]   rsp_status;
  logic         inv_start, inv_finish, inv_kill;

  mod_inv_host #(.W(W), .TO_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_p      (req_p),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_inv    (rsp_inv),
    .rsp_status (rsp_status),
    .inv_start  (inv_start),
    .inv_in     (inv_in),
    .inv_p      (inv_p),
    .inv_res    (inv_res),
    .inv_finish (inv_finish),
    .inv_kill   (inv_kill)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Inverter stub: mode 0 returns the true inverse, mode 1 a fixed value, mode 2 never finishes.
  int           stub_mode = 0;
  int           stub_lat = 4;
  logic [W-1:0] stub_val = '0;
  int           stub_cnt;

  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] a, input logic [W-1:0] p);
    int ai, pi;
    ai = int'(a[15:0]);
    pi = int'(p[15:0]);
    for (int x = 1; x < pi; x++) if ((ai * x) % pi == 1) return W'(x);
    return '0;
  endfunction

  always @(posedge clk) begin
    inv_finish <= 1'b0;
    if (inv_kill) begin
      stub_cnt <= 0;
      inv_res  <= '0;
    end else if (inv_start && stub_mode != 2) begin
      stub_cnt <= stub_lat;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        inv_finish <= 1'b1;
        inv_res    <= (stub_mode == 0) ? ref_inv(inv_in, inv_p) : stub_val;
      end
    end
  end

  int start_cyc = -1, fin_cyc = -1, n_start = 0, n_kill = 0;
  always @(negedge clk) begin
    if (inv_start) begin
      start_cyc = cyc;
      n_start   = n_start + 1;
    end
    if (inv_finish) fin_cyc = cyc;
    if (inv_kill && !rst) n_kill = n_kill + 1;
  end

  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] p, output int n_acc);
    int g;
    @(negedge clk);
    req_a     = a;
    req_p     = p;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    n_acc = req_ready ? cyc : -1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output int n_rsp);
    int g;
    g = 0;
    @(negedge clk);
    while (!rsp_valid && g < TO + W + 64) begin
      @(negedge clk);
      g++;
    end
    ok    = rsp_valid;
    n_rsp = cyc;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] p;
    int           mode;
    logic [W-1:0] val;
    int           lat;
    logic [1:0]   st;
    logic [W-1:0] inv;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  initial begin
    int n_acc, n_rsp, st0, k0, h;
    bit ok;
    logic [W-1:0] big_p, v_inv;
    logic [1:0] v_st;

    big_p = {W{1'b1}} - W'(188);
    tbl[0] = '{W'(5),  W'(13), 0, W'(0),  4, ST_OK,     W'(8)};
    tbl[1] = '{W'(0),  W'(13), 0, W'(0),  4, ST_BADARG, W'(0)};
    tbl[2] = '{W'(13), W'(13), 0, W'(0),  4, ST_BADARG, W'(0)};
    tbl[3] = '{W'(3),  W'(10), 0, W'(0),  4, ST_BADARG, W'(0)};
    tbl[4] = '{W'(5),  W'(13), 1, W'(7),  6, ST_VFAIL,  W'(7)};
    tbl[5] = '{W'(1),  W'(3),  0, W'(0),  1, ST_OK,     W'(1)};
    tbl[6] = '{W'(1),  W'(2),  0, W'(0),  4, ST_BADARG, W'(0)};
    tbl[7] = '{W'(7),  W'(11), 1, W'(19), 3, ST_VFAIL,  W'(19)};
    tbl[8] = '{big_p - W'(1), big_p, 1, big_p - W'(1), 5, ST_OK, big_p - W'(1)};
    tbl[9] = '{W'(12), W'(13), 0, W'(0),  9, ST_OK,     W'(12)};

    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_p     = '0;
    repeat (3) @(negedge clk);
    chk("reset_kill", W'(inv_kill), W'(1));
    chk("reset_ready_low", W'(req_ready), W'(0));
    chk("reset_rsp_valid", W'(rsp_valid), W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", W'(req_ready), W'(1));
    chk("post_reset_start", W'(inv_start), W'(0));
    chk("post_reset_inv_in", inv_in, W'(0));
    chk("post_reset_kill", W'(inv_kill), W'(0));

    for (int i = 0; i < NV; i++) begin
      stub_mode = tbl[i].mode;
      stub_val  = tbl[i].val;
      stub_lat  = tbl[i].lat;
      st0 = n_start;
      send_req(tbl[i].a, tbl[i].p, n_acc);
      chk($sformatf("v%0d_accept", i), W'(n_acc >= 0), W'(1));
      wait_rsp(ok, n_rsp);
      chk($sformatf("v%0d_rsp_seen", i), W'(ok), W'(1));
      chk($sformatf("v%0d_status", i), W'(rsp_status), W'(tbl[i].st));
      chk($sformatf("v%0d_inv", i), rsp_inv, tbl[i].inv);
      if (tbl[i].st == ST_BADARG) begin
        chk($sformatf("v%0d_badarg_lat", i), W'(n_rsp), W'(n_acc + 2));
        chk($sformatf("v%0d_no_start", i), W'(n_start), W'(st0));
      end else begin
        chk($sformatf("v%0d_start_cyc", i), W'(start_cyc), W'(n_acc + 2));
        chk($sformatf("v%0d_verify_lat", i), W'(n_rsp), W'(fin_cyc + W + 1));
      end
      take_rsp();
    end

    // Inverter never finishes: watchdog expiry, one kill pulse, zero result.
    stub_mode = 2;
    k0 = n_kill;
    send_req(W'(5), W'(13), n_acc);
    wait_rsp(ok, n_rsp);
    chk("to_rsp_seen", W'(ok), W'(1));
    chk("to_status", W'(rsp_status), W'(ST_TIMEOUT));
    chk("to_inv", rsp_inv, W'(0));
    chk("to_latency", W'(n_rsp), W'(n_acc + 3 + TO));
    take_rsp();
    repeat (3) @(negedge clk);
    chk("to_kill_pulses", W'(n_kill - k0), W'(1));

    // Backpressure: response held while rsp_ready is low, next job accepted one cycle after the handshake.
    stub_mode = 0;
    stub_lat  = 3;
    send_req(W'(3), W'(11), n_acc);
    wait_rsp(ok, n_rsp);
    chk("bp_rsp_seen", W'(ok), W'(1));
    chk("bp_inv", rsp_inv, W'(4));
    v_inv = rsp_inv;
    v_st  = rsp_status;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), W'(rsp_valid), W'(1));
      chk($sformatf("bp_hold%0d_inv", k), rsp_inv, v_inv);
      chk($sformatf("bp_hold%0d_status", k), W'(rsp_status), W'(v_st));
      chk($sformatf("bp_hold%0d_ready", k), W'(req_ready), W'(0));
    end
    h         = cyc;
    rsp_ready = 1'b1;
    req_a     = W'(12);
    req_p     = W'(13);
    req_valid = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_ready", W'(req_ready), W'(1));
    chk("bp_next_cycle", W'(cyc), W'(h + 1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(ok, n_rsp);
    chk("bp_next_status", W'(rsp_status), W'(ST_OK));
    chk("bp_next_inv", rsp_inv, W'(12));
    take_rsp();

    // Reset in the middle of WAIT, then a fresh job.
    stub_lat = 100;
    send_req(W'(5), W'(13), n_acc);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_kill", W'(inv_kill), W'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", W'(req_ready), W'(1));
    chk("mid_rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("mid_rst_start", W'(inv_start), W'(0));
    chk("mid_rst_inv", rsp_inv, W'(0));
    chk("mid_rst_status", W'(rsp_status), W'(0));
    chk("mid_rst_inv_in", inv_in, W'(0));
    chk("mid_rst_inv_p", inv_p, W'(0));
    stub_lat = 4;
    send_req(W'(3), W'(11), n_acc);
    wait_rsp(ok, n_rsp);
    chk("after_rst_status", W'(rsp_status), W'(ST_OK));
    chk("after_rst_inv", rsp_inv, W'(4));
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
